fnd_scan_controller: RTL and testbench

//  Drives the 4-digit FND multiplex path: converts a 14-bit binary number to BCD, then scans the digits.

---
 rtl/fnd_pkg.sv | 35 +++
 rtl/bin2bcd_dd.sv | 62 ++++++
 rtl/fnd_scan_controller.sv | 106 ++++++++++
 tb/tb_fnd_scan_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scan path.
// Imported by the BCD converter and the scan controller.
package fnd_pkg;

  localparam int FND_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam int BIN_W      = 14;

  localparam logic [BIN_W-1:0] FND_MAX_VALUE = 14'd9999;
  localparam logic [3:0]       DD_LAST       = 4'd13;

  localparam logic [1:0] DIG_ONES  = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_HUND  = 2'd2;
  localparam logic [1:0] DIG_THOUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic [BCD_W-1:0] dd_adjust(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < FND_DIGITS; k++) begin
      if (b[4*k +: 4] >= 4'd5)
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble: 14-bit binary to 4-digit BCD,
// one iteration per clock, result presented during ST_DONE.
module bin2bcd_dd
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ready
);

  state_t           state_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic [BCD_W-1:0] adj;

  assign adj     = dd_adjust(bcd_q);
  assign o_bcd   = bcd_q;
  assign o_busy  = busy_q;
  assign o_done  = (state_q == ST_DONE);
  assign o_ready = (state_q != ST_SHIFT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // a start in the result cycle restarts right away
          if (i_start) begin
            bin_q   <= i_bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {adj, bin_q} << 1;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == DD_LAST)
            state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: clamps and converts the operand
// to BCD, then multiplexes digits with leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1_000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [BIN_W-1:0] i_number,
  input  logic             i_blank_lz,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_value,
  output logic             o_en
);

  localparam int unsigned DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  logic [PW-1:0]    ps_q;
  logic [1:0]       sel_q;
  logic [1:0]       sel_d;
  logic [BCD_W-1:0] disp_q;
  logic [3:0]       val_q;
  logic             en_q;
  logic             en_d;
  logic             done_q;
  logic             ovf_q;
  logic             tick;
  logic             clamp;
  logic             load_ok;
  logic [BIN_W-1:0] operand;
  logic [3:1]       nz;
  logic             dd_busy;
  logic             dd_done;
  logic             dd_ready;
  logic [BCD_W-1:0] dd_bcd;

  assign clamp   = (i_number > FND_MAX_VALUE);
  assign operand = clamp ? FND_MAX_VALUE : i_number;
  assign load_ok = i_load & dd_ready;
  assign tick    = (ps_q == PS_LAST);
  assign sel_d   = tick ? sel_q + 2'd1 : sel_q;

  assign nz = {|disp_q[15:12], |disp_q[11:8], |disp_q[7:4]};

  always_comb begin
    en_d = 1'b1;
    unique case (sel_d)
      DIG_ONES:  en_d = 1'b1;
      DIG_TENS:  en_d = !i_blank_lz | (|nz[3:1]);
      DIG_HUND:  en_d = !i_blank_lz | (|nz[3:2]);
      DIG_THOUS: en_d = !i_blank_lz | nz[3];
    endcase
  end

  bin2bcd_dd u_dd (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (load_ok),
    .i_bin     (operand),
    .o_bcd     (dd_bcd),
    .o_busy    (dd_busy),
    .o_done    (dd_done),
    .o_ready   (dd_ready)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ps_q   <= '0;
      sel_q  <= DIG_ONES;
      disp_q <= '0;
      val_q  <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ps_q <= tick ? '0 : ps_q + 1'b1;
      // digit data only moves with the select so they never disagree
      if (tick) begin
        sel_q <= sel_d;
        val_q <= disp_q[{sel_d, 2'b00} +: 4];
        en_q  <= en_d;
      end
      done_q <= dd_done;
      if (dd_done)
        disp_q <= dd_bcd;
      if (load_ok)
        ovf_q <= clamp;
    end
  end

  assign o_busy        = dd_busy;
  assign o_done        = done_q;
  assign o_ovf         = ovf_q;
  assign o_digitSelect = sel_q;
  assign o_value       = val_q;
  assign o_en          = en_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller (DIV = 4).
// Loads push expected results; monitors check done and scan.
module tb_fnd_scan_controller;

  localparam int DIV = 4;

  typedef struct {
    int          cyc;
    bit          ovf;
    logic [15:0] bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_load;
  logic [13:0] i_number;
  logic        i_blank_lz;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_value;
  logic        o_en;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  logic [15:0] model_disp = 16'h0;
  bit          blank_s = 1'b0;
  logic [1:0]  prev_sel = 2'd0;
  bit          have_prev = 1'b0;
  int          hold = 0;

  fnd_scan_controller #(
    .CLK_FREQ (1000),
    .SCAN_HZ  (250)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_load        (i_load),
    .i_number      (i_number),
    .i_blank_lz    (i_blank_lz),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_ovf         (o_ovf),
    .o_digitSelect (o_digitSelect),
    .o_value       (o_value),
    .o_en          (o_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    blank_s <= i_blank_lz;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_en(input logic [1:0] s,
                                input logic [15:0] d,
                                input bit b);
    int msd = 0;
    for (int k = 0; k < 4; k++)
      if (d[4*k +: 4] != 4'd0) msd = k;
    return (s == 2'd0) || !b || (int'(s) <= msd);
  endfunction

  // monitor: scan positions and done pulses
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      model_disp = 16'h0;
      have_prev  = 1'b0;
      hold       = 0;
      prev_sel   = 2'd0;
    end else begin
      hold++;
      if (o_digitSelect != prev_sel) begin
        if (have_prev) begin
          chk("scan_hold", hold, DIV);
          chk("scan_order", int'(o_digitSelect),
              int'(2'(prev_sel + 2'd1)));
        end
        chk("scan_val", int'(o_value),
            int'(model_disp[4*o_digitSelect +: 4]));
        chk("scan_en", int'(o_en),
            int'(exp_en(o_digitSelect, model_disp, blank_s)));
        hold      = 0;
        have_prev = 1'b1;
        prev_sel  = o_digitSelect;
      end
      if (o_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_done=1 expected 0 at cycle %0d",
                   cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_ovf", int'(o_ovf), int'(e.ovf));
          chk("done_busy", int'(o_busy), 0);
          model_disp = e.bcd;
        end
      end
    end
  end

  task automatic load_now(input logic [13:0] n, input bit acc,
                          input bit ovf, input logic [15:0] bcd);
    exp_t e;
    i_number = n;
    i_load   = 1'b1;
    if (acc) begin
      e.cyc = cyc + 16;
      e.ovf = ovf;
      e.bcd = bcd;
      sb_q.push_back(e);
    end
    @(negedge clk);
    i_load = 1'b0;
  endtask

  task automatic load(input logic [13:0] n, input bit acc,
                      input bit ovf, input logic [15:0] bcd);
    @(negedge clk);
    load_now(n, acc, ovf, bcd);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0",
               sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic scan(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n      = 1'b0;
    i_load     = 1'b0;
    i_number   = '0;
    i_blank_lz = 1'b0;

    // reset state and first scan step
    repeat (5) @(negedge clk);
    #1;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_ovf", int'(o_ovf), 0);
    chk("rst_sel", int'(o_digitSelect), 0);
    chk("rst_val", int'(o_value), 0);
    chk("rst_en", int'(o_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_tick_sel", int'(o_digitSelect), 0);
    chk("pre_tick_en", int'(o_en), 0);
    @(negedge clk);
    #1;
    chk("tick4_sel", int'(o_digitSelect), 1);
    chk("tick4_en", int'(o_en), 1);
    chk("tick4_val", int'(o_value), 0);

    // basic conversion
    load(14'd1234, 1'b1, 1'b0, 16'h1234);
    drain();
    scan(20);

    // clamp and recovery
    load(14'd12345, 1'b1, 1'b1, 16'h9999);
    drain();
    chk("ovf_set", int'(o_ovf), 1);
    scan(16);
    load(14'd42, 1'b1, 1'b0, 16'h0042);
    drain();
    chk("ovf_clr", int'(o_ovf), 0);
    scan(16);

    // leading-zero blanking
    i_blank_lz = 1'b1;
    load(14'd7, 1'b1, 1'b0, 16'h0007);
    drain();
    scan(20);
    i_blank_lz = 1'b0;
    scan(20);
    i_blank_lz = 1'b1;
    load(14'd0, 1'b1, 1'b0, 16'h0000);
    drain();
    scan(20);
    i_blank_lz = 1'b0;

    // load while busy ignored, load on done pulse accepted
    load(14'd1111, 1'b1, 1'b0, 16'h1111);
    repeat (3) @(negedge clk);
    load_now(14'd5678, 1'b0, 1'b0, 16'h0);
    #1;
    chk("busy_hold", int'(o_busy), 1);
    chk("ovf_hold", int'(o_ovf), 0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (o_done) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no o_done expected pulse");
    end
    load_now(14'd4321, 1'b1, 1'b0, 16'h4321);
    drain();
    scan(20);

    // reset mid-conversion aborts
    load(14'd9999, 1'b0, 1'b0, 16'h0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_done", int'(o_done), 0);
    chk("abort_sel", int'(o_digitSelect), 0);
    chk("abort_en", int'(o_en), 0);
    chk("abort_val", int'(o_value), 0);
    chk("abort_ovf", int'(o_ovf), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scan(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
